// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter/router.
// Holds the FSM state encoding, the ID-field width, the arbitration mode
// encodings and a helper that extracts the destination ID from a packet.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  localparam int ID_W       = 8;
  localparam int IDX_W      = 4;   // wide enough for up to 16 devices
  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;
  localparam int MAX_PKT_W  = 256; // widest packet id_of() accepts

  // Destination ID lives in the top ID_W bits of a pkt_w-bit packet.
  // The packet is passed zero-extended to MAX_PKT_W bits.
  function automatic logic [ID_W-1:0] id_of(input logic [MAX_PKT_W-1:0] packet,
                                            input int pkt_w);
    return ID_W'(packet >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner picker for the bus arbiter.
// Rotates the request vector so the search starts at the pointer, takes the
// lowest set bit of the rotated vector, then maps it back to a device index.
// Ports:
//   req   - request vector, one bit per device
//   ptr   - round-robin start index (ignored in fixed mode)
//   mode  - 0 = round-robin, 1 = fixed priority (lowest index wins)
//   valid - at least one request present
//   idx   - index of the winning device
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] base;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Rotate-and-encode: doubling the vector makes the wrap-around a plain shift
  always_comb begin
    base  = (mode == 1'b1) ? {IDX_W{1'b0}} : ptr;
    rot   = N'({req, req} >> base);
    off   = {IDX_W{1'b0}};
    // Scan downwards so the lowest set bit is the one that sticks
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
      end else begin
        off = off;
      end
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (IDX_W+1)'(N)) begin
      idx = IDX_W'(sum - (IDX_W+1)'(N));
    end else begin
      idx = sum[IDX_W-1:0];
    end
    valid = |req;
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Shared-bus arbiter/router for drvrs FIFO-fronted devices.
// Each transfer runs IDLE -> POP -> PUSH: pick a pending device, pop its head
// packet, then deliver it by the destination ID in the packet's top byte as a
// unicast, a broadcast (everyone but the source) or a counted drop.
// Ports:
//   clk, reset - clock and asynchronous active-high reset
//   pndng      - per-device "FIFO not empty"
//   D_pop      - per-device head packet, device i at [i*pckg_sz +: pckg_sz]
//   pop        - one-hot pop strobe to the granted device
//   push       - push strobe(s) to destination device(s)
//   D_push     - packet being delivered (valid while any push bit is high)
//   busy       - FSM not in IDLE
//   gnt_id     - index of the last granted device
//   drop_cnt   - saturating count of packets with an invalid ID
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter int         mode      = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic                     busy,
  output logic [3:0]               gnt_id,
  output logic [15:0]              drop_cnt
);

  localparam logic FIXED = (mode == MODE_FIXED) ? 1'b1 : 1'b0;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_next;
  logic [pckg_sz-1:0] packet;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               src_pend;
  logic [pckg_sz-1:0] src_data;
  logic [ID_W-1:0]    id;
  logic               is_bcast;
  logic               is_uni;
  logic               is_drop;

  rr_picker #(.N(drvrs)) u_picker (
    .req   (pndng),
    .ptr   (ptr),
    .mode  (FIXED),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign ptr_next = (gnt_id == IDX_W'(drvrs - 1)) ? {IDX_W{1'b0}} : gnt_id + 4'd1;
  assign busy     = (state != IDLE);
  assign D_push   = packet;

  // Select the granted device's pending flag and head packet
  always_comb begin
    src_pend = 1'b0;
    src_data = {pckg_sz{1'b0}};
    for (int i = 0; i < drvrs; i++) begin
      src_pend = (IDX_W'(i) == gnt_id) ? pndng[i] : src_pend;
      src_data = (IDX_W'(i) == gnt_id) ? D_pop[i*pckg_sz +: pckg_sz] : src_data;
    end
  end

  // Classify the captured packet; broadcast is checked first so it always wins
  always_comb begin
    id       = id_of(MAX_PKT_W'(packet), pckg_sz);
    is_bcast = (id == broadcast);
    is_uni   = !is_bcast && (int'(id) < drvrs);
    is_drop  = !is_bcast && !is_uni;
  end

  // Strobes decode straight from state so an asynchronous reset kills them at once
  always_comb begin
    pop  = {drvrs{1'b0}};
    push = {drvrs{1'b0}};
    for (int i = 0; i < drvrs; i++) begin
      pop[i]  = (state == POP) && src_pend && (IDX_W'(i) == gnt_id);
      push[i] = (state == PUSH) &&
                ((is_uni && (id == ID_W'(i))) || (is_bcast && (IDX_W'(i) != gnt_id)));
    end
  end

  // Transfer FSM with grant, pointer, packet register and drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt_id   <= 4'd0;
      ptr      <= {IDX_W{1'b0}};
      packet   <= {pckg_sz{1'b0}};
      drop_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_id <= pick_idx;
            state  <= POP;
          end else begin
            state  <= IDLE;
          end
        end
        POP: begin
          // Source may have emptied since it was picked; abort without moving the pointer
          if (src_pend) begin
            packet <= src_data;
            ptr    <= ptr_next;
            state  <= PUSH;
          end else begin
            state  <= IDLE;
          end
        end
        PUSH: begin
          if (is_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
module tb_bus_rr_arbiter;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [3:0]  pv;
    logic [3:0]  sv;
    logic [15:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] D_pop;
  logic [3:0]  pop_rr, push_rr, gnt_rr;
  logic [15:0] D_push_rr, drop_rr;
  logic        busy_rr;
  logic [3:0]  pop_fx, push_fx, gnt_fx;
  logic [15:0] D_push_fx, drop_fx;
  logic        busy_fx;

  txn_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .mode(0)) dut_rr (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop_rr), .push(push_rr), .D_push(D_push_rr), .busy(busy_rr),
    .gnt_id(gnt_rr), .drop_cnt(drop_rr)
  );

  bus_rr_arbiter #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .mode(1)) dut_fx (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop_fx), .push(push_fx), .D_push(D_push_fx), .busy(busy_fx),
    .gnt_id(gnt_fx), .drop_cnt(drop_fx)
  );

  task automatic set_pkt(input int dev, input logic [15:0] v);
    D_pop[dev*16 +: 16] = v;
  endtask

  // Wait (bounded) for the round-robin instance to issue a pop
  task automatic wait_pop(input string tag, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pop_rr != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_pop_timeout no pop within 10 cycles", tag);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pndng = 4'hF; D_pop = 64'd0;
    #2;
    checks++; if ({pop_rr, push_rr, busy_rr, gnt_rr} !== 13'd0) begin errors++; $display("FAIL reset_ctl got=%b exp=0", {pop_rr, push_rr, busy_rr, gnt_rr}); end
    checks++; if ({D_push_rr, drop_rr} !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {D_push_rr, drop_rr}); end
    @(negedge clk);
    checks++; if ({pop_rr, busy_rr} !== 5'd0) begin errors++; $display("FAIL reset_nopop got=%b exp=0", {pop_rr, busy_rr}); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (pop_rr !== 4'b0001) begin errors++; $display("FAIL reset_first_pop got=%b exp=0001", pop_rr); end
    @(negedge clk);
    pndng = 4'h0;
    @(negedge clk);
    checks++; if (busy_rr !== 1'b0) begin errors++; $display("FAIL reset_idle busy got=%b exp=0", busy_rr); end
  endtask

  task automatic test_unicast();
    txn_t e; bit ok;
    set_pkt(1, 16'h02AB); pndng = 4'b0010;
    sb.push_back('{gnt: 4'd1, pv: 4'b0010, sv: 4'b0100, data: 16'h02AB});
    wait_pop("unicast", ok);
    if (ok) begin
      e = sb.pop_front();
      checks++; if (pop_rr !== e.pv) begin errors++; $display("FAIL unicast_pop got=%b exp=%b", pop_rr, e.pv); end
      checks++; if (gnt_rr !== e.gnt) begin errors++; $display("FAIL unicast_gnt got=%0d exp=%0d", gnt_rr, e.gnt); end
      @(negedge clk);
      pndng = 4'b0000;
      checks++; if (push_rr !== e.sv) begin errors++; $display("FAIL unicast_push got=%b exp=%b", push_rr, e.sv); end
      checks++; if (D_push_rr !== e.data) begin errors++; $display("FAIL unicast_data got=%h exp=%h", D_push_rr, e.data); end
      @(negedge clk);
      checks++; if ({busy_rr, push_rr} !== 5'd0) begin errors++; $display("FAIL unicast_idle got=%b exp=0", {busy_rr, push_rr}); end
    end
  endtask

  task automatic test_broadcast();
    txn_t e; bit ok;
    set_pkt(0, 16'hFF55); pndng = 4'b0001;
    sb.push_back('{gnt: 4'd0, pv: 4'b0001, sv: 4'b1110, data: 16'hFF55});
    wait_pop("bcast", ok);
    if (ok) begin
      e = sb.pop_front();
      checks++; if (pop_rr !== e.pv) begin errors++; $display("FAIL bcast_pop got=%b exp=%b", pop_rr, e.pv); end
      @(negedge clk);
      pndng = 4'b0000;
      checks++; if (push_rr !== e.sv) begin errors++; $display("FAIL bcast_push got=%b exp=%b", push_rr, e.sv); end
      checks++; if (D_push_rr !== e.data) begin errors++; $display("FAIL bcast_data got=%h exp=%h", D_push_rr, e.data); end
      @(negedge clk);
      checks++; if (drop_rr !== 16'd0) begin errors++; $display("FAIL bcast_drop got=%h exp=0000", drop_rr); end
    end
  endtask

  task automatic test_invalid(input logic [15:0] exp_cnt, input string tag);
    txn_t e; bit ok;
    set_pkt(3, 16'h0712); pndng = 4'b1000;
    sb.push_back('{gnt: 4'd3, pv: 4'b1000, sv: 4'b0000, data: 16'h0712});
    wait_pop(tag, ok);
    if (ok) begin
      e = sb.pop_front();
      checks++; if (pop_rr !== e.pv) begin errors++; $display("FAIL %s_pop got=%b exp=%b", tag, pop_rr, e.pv); end
      @(negedge clk);
      pndng = 4'b0000;
      checks++; if (push_rr !== e.sv) begin errors++; $display("FAIL %s_push got=%b exp=%b", tag, push_rr, e.sv); end
      @(negedge clk);
      checks++; if (drop_rr !== exp_cnt) begin errors++; $display("FAIL %s_cnt got=%h exp=%h", tag, drop_rr, exp_cnt); end
    end
  endtask

  task automatic test_saturate();
    force dut_rr.drop_cnt = 16'hFFFF;
    #1;
    release dut_rr.drop_cnt;
    test_invalid(16'hFFFF, "saturate");
  endtask

  task automatic test_abort();
    txn_t e; bit ok;
    // Pointer is 0 here; device 2 is picked then withdraws
    set_pkt(2, 16'h0011); pndng = 4'b0100;
    @(negedge clk);
    checks++; if (gnt_rr !== 4'd2 || busy_rr !== 1'b1) begin errors++; $display("FAIL abort_grant got=%0d/%b exp=2/1", gnt_rr, busy_rr); end
    pndng = 4'b0000;
    #1;
    checks++; if (pop_rr !== 4'b0000) begin errors++; $display("FAIL abort_pop got=%b exp=0000", pop_rr); end
    @(negedge clk);
    checks++; if ({busy_rr, pop_rr, push_rr} !== 9'd0) begin errors++; $display("FAIL abort_idle got=%b exp=0", {busy_rr, pop_rr, push_rr}); end
    // An unchanged pointer (0) picks 2 out of {2,3}; a moved one (3) would pick 3
    set_pkt(3, 16'h0033); pndng = 4'b1100;
    sb.push_back('{gnt: 4'd2, pv: 4'b0100, sv: 4'b0001, data: 16'h0011});
    wait_pop("abort_next", ok);
    if (ok) begin
      e = sb.pop_front();
      checks++; if (gnt_rr !== e.gnt) begin errors++; $display("FAIL abort_ptr gnt got=%0d exp=%0d", gnt_rr, e.gnt); end
      checks++; if (pop_rr !== e.pv) begin errors++; $display("FAIL abort_next_pop got=%b exp=%b", pop_rr, e.pv); end
      @(negedge clk);
      pndng = 4'b0000;
      checks++; if (push_rr !== e.sv || D_push_rr !== e.data) begin errors++; $display("FAIL abort_next_push got=%b/%h exp=%b/%h", push_rr, D_push_rr, e.sv, e.data); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_push();
    bit ok;
    set_pkt(1, 16'h0222); pndng = 4'b0010;
    wait_pop("rstpush", ok);
    if (ok) begin
      checks++; if (pop_rr !== 4'b0010) begin errors++; $display("FAIL rstpush_pop got=%b exp=0010", pop_rr); end
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checks++; if ({push_rr, pop_rr, busy_rr, gnt_rr} !== 13'd0) begin errors++; $display("FAIL rstpush_ctl got=%b exp=0", {push_rr, pop_rr, busy_rr, gnt_rr}); end
      checks++; if ({D_push_rr, drop_rr} !== 32'd0) begin errors++; $display("FAIL rstpush_data got=%h exp=0", {D_push_rr, drop_rr}); end
      @(negedge clk);
      reset = 1'b0; D_pop = 64'd0; pndng = 4'b1111;
      wait_pop("rstpush_ptr", ok);
      if (ok) begin
        checks++; if (gnt_rr !== 4'd0 || pop_rr !== 4'b0001) begin errors++; $display("FAIL rstpush_ptr got=%0d/%b exp=0/0001", gnt_rr, pop_rr); end
        @(negedge clk);
        pndng = 4'b0000;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_fairness();
    txn_t e;
    int n = 0;
    int last = -1;
    @(negedge clk); reset = 1'b1; pndng = 4'b0000;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 4; i++) set_pkt(i, 16'h00A0 + 16'(i));
    for (int i = 0; i < 5; i++) sb.push_back('{gnt: 4'(i % 4), pv: 4'(1 << (i % 4)), sv: 4'b0001, data: 16'h00A0 + 16'(i % 4)});
    pndng = 4'b1111;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (pop_rr != 4'b0000) begin
        e = sb.pop_front();
        checks++; if (pop_rr !== e.pv || gnt_rr !== e.gnt) begin errors++; $display("FAIL rr_grant%0d got=%b/%0d exp=%b/%0d", n, pop_rr, gnt_rr, e.pv, e.gnt); end
        checks++; if (pop_fx !== 4'b0001 || gnt_fx !== 4'd0) begin errors++; $display("FAIL fixed_grant%0d got=%b/%0d exp=0001/0", n, pop_fx, gnt_fx); end
        if (last >= 0) begin
          checks++; if (c - last != 3) begin errors++; $display("FAIL rr_gap%0d got=%0d exp=3", n, c - last); end
        end
        last = c;
        @(negedge clk); c++;
        checks++; if (push_rr !== e.sv || D_push_rr !== e.data) begin errors++; $display("FAIL rr_push%0d got=%b/%h exp=%b/%h", n, push_rr, D_push_rr, e.sv, e.data); end
        checks++; if (push_fx !== 4'b0001 || D_push_fx !== 16'h00A0) begin errors++; $display("FAIL fixed_push%0d got=%b/%h exp=0001/00a0", n, push_fx, D_push_fx); end
        n++;
        if (n == 5) pndng = 4'b0000;
      end
    end
    if (n != 5) begin
      checks++; errors++;
      $display("FAIL rr_timeout got=%0d exp=5 transfers", n);
      pndng = 4'b0000;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_broadcast();
    test_invalid(16'd1, "invalid");
    test_saturate();
    test_abort();
    test_reset_in_push();
    test_fairness();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
